// File: rtl/ahb_apb_pkg.sv
// Shared types and AHB encodings for the AHB-Lite to APB3 bridge.
// Nothing in this file has latency or backpressure of its own.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } bridge_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts PREADY-low ACCESS cycles; tc is combinational and fires in the cycle that reaches the limit.
// No backpressure: the caller clears it on SETUP entry and enables it while the slave stalls.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // A limit of zero disables the abort entirely.
    assign tc = (TIMEOUT_CYCLES > 0) && en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc && (TIMEOUT_CYCLES > 0)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ahbl_to_apb3_bridge.sv
// Single-slave AHB-Lite to APB3 bridge; each transfer costs 2 wait states plus one per PREADY-low cycle.
// Stalls AHB via HREADYOUT while the APB cycle runs; errors use the AHB two-cycle ERROR response.
module ahbl_to_apb3_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    bridge_state_t state, state_nxt;

    logic xfer_vld;
    logic illegal;
    logic psel_nxt, penable_nxt, hreadyout_nxt, hresp_nxt;
    logic cap_addr, cap_wdata, cap_rdata;
    logic cnt_clr, cnt_en, cnt_tc;

    assign xfer_vld = HSEL && HREADYIN && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    // Reads narrower than a word are passed through; only sub-word writes are refused.
    assign illegal  = HWRITE && (HSIZE != HSIZE_WORD);

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk(HCLK),
        .rst(HRESET),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (cnt_tc)
    );

    always_comb begin
        state_nxt = state;
        cap_addr  = 1'b0;
        cap_wdata = 1'b0;
        cap_rdata = 1'b0;
        cnt_en    = 1'b0;

        case (state)
            IDLE, ERR2: begin
                if (xfer_vld && illegal) begin
                    state_nxt = ERR1;
                end else if (xfer_vld) begin
                    state_nxt = SETUP;
                    cap_addr  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                cap_wdata = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                cnt_en = !PREADY;
                if (PREADY && PSLVERR) begin
                    state_nxt = ERR1;
                end else if (PREADY) begin
                    state_nxt = IDLE;
                    cap_rdata = !PWRITE;
                end else if (cnt_tc) begin
                    state_nxt = ERR1;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase

        cnt_clr = (state_nxt == SETUP);

        // Outputs are decoded from the next state so they come straight out of flops.
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        hreadyout_nxt = 1'b1;
        hresp_nxt     = HRESP_OKAY;
        case (state_nxt)
            SETUP: begin
                psel_nxt      = 1'b1;
                hreadyout_nxt = 1'b0;
            end
            ACCESS: begin
                psel_nxt      = 1'b1;
                penable_nxt   = 1'b1;
                hreadyout_nxt = 1'b0;
            end
            ERR1: begin
                hreadyout_nxt = 1'b0;
                hresp_nxt     = HRESP_ERROR;
            end
            ERR2: begin
                hresp_nxt     = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            HRDATA    <= '0;
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            HREADYOUT <= hreadyout_nxt;
            HRESP     <= hresp_nxt;
            if (cap_addr) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            if (cap_wdata) begin
                PWDATA <= HWDATA;
            end
            if (cap_rdata) begin
                HRDATA <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_to_apb3_bridge.sv
// Directed bench for the AHB-Lite to APB3 bridge: a vector table of whole transfers plus
// hand-written cycle sequences for back-to-back, ERR2 acceptance and reset mid-ACCESS.
module tb_ahbl_to_apb3_bridge;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          n_cmp = 0;
    int          n_bad = 0;

    // APB responder: PREADY rises after ready_delay stalled ACCESS cycles.
    int          ready_delay = 0;
    logic        slverr_v = 1'b0;
    logic [31:0] prdata_v = '0;
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    assign hreadyin = hreadyout;
    assign pready   = psel && penable && (acc_cnt >= ready_delay);
    assign pslverr  = pready && slverr_v;
    assign prdata   = prdata_v;

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    ahbl_to_apb3_bridge #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK     (clk),
        .HRESET   (hreset),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADYIN (hreadyin),
        .HRDATA   (hrdata),
        .HREADYOUT(hreadyout),
        .HRESP    (hresp),
        .PADDR    (paddr),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PWDATA   (pwdata),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr)
    );

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        int          delay;
        logic        slverr;
        int          exp_wait;
        int          exp_acc;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = '0;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                              input logic [31:0] a);
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n;
        int   nacc;
        logic saw_psel;
        logic apb_ok;
        logic last_resp;
        ready_delay = v.delay;
        slverr_v    = v.slverr;
        prdata_v    = v.prdata;
        hsel   = v.hsel;
        htrans = v.htrans;
        hwrite = v.hwrite;
        hsize  = v.hsize;
        haddr  = v.haddr;
        tick();
        bus_idle();
        hwdata    = v.hwdata;
        n         = 0;
        nacc      = 0;
        saw_psel  = 1'b0;
        apb_ok    = 1'b1;
        last_resp = 1'b0;
        while (!hreadyout && n < 64) begin
            if (psel) begin
                saw_psel = 1'b1;
                if (paddr !== v.haddr || pwrite !== v.hwrite) apb_ok = 1'b0;
                if (penable) begin
                    nacc++;
                    if (v.hwrite && pwdata !== v.hwdata) apb_ok = 1'b0;
                end
            end
            last_resp = hresp;
            tick();
            n++;
        end
        chk($sformatf("v%0d_wait_states", idx), n, v.exp_wait);
        chk($sformatf("v%0d_access_cycles", idx), nacc, v.exp_acc);
        chk($sformatf("v%0d_psel_seen", idx), {31'b0, saw_psel}, {31'b0, v.exp_acc != 0});
        chk($sformatf("v%0d_apb_stable", idx), {31'b0, apb_ok}, 32'd1);
        chk($sformatf("v%0d_hresp_done", idx), {31'b0, hresp}, {31'b0, v.exp_resp});
        if (n > 0) chk($sformatf("v%0d_hresp_last_wait", idx), {31'b0, last_resp}, {31'b0, v.exp_resp});
        chk($sformatf("v%0d_hrdata", idx), hrdata, v.exp_rdata);
        if (v.exp_resp) begin
            tick();
            chk($sformatf("v%0d_hresp_cleared", idx), {31'b0, hresp}, 32'd0);
        end
        hwdata   = '0;
        slverr_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        //               hsel  htrans wr    size   haddr         hwdata        prdata        dly err   wait acc resp  exp_rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h4000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 2, 1, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 2'b10, 1'b1, 3'd2, 32'h4000_0020, 32'h1234_5678, 32'h0,       3, 1'b0, 5, 4, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 3'd0, 32'h4000_0023, 32'h0,        32'hA5A5_0011, 1, 1'b0, 3, 2, 1'b0, 32'hA5A5_0011};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h4000_0004, 32'h0,        32'hFFFF_FFFF, 0, 1'b1, 3, 1, 1'b1, 32'hA5A5_0011};
        vecs[4]  = '{1'b1, 2'b10, 1'b1, 3'd0, 32'h4000_0008, 32'hCAFE_F00D, 32'h0,       0, 1'b0, 1, 0, 1'b1, 32'hA5A5_0011};
        vecs[5]  = '{1'b1, 2'b10, 1'b1, 3'd2, 32'h4000_000C, 32'h8765_4321, 32'h0,       2, 1'b1, 5, 3, 1'b1, 32'hA5A5_0011};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h4000_0030, 32'h0,        32'h7777_7777, 255, 1'b0, 6, 4, 1'b1, 32'hA5A5_0011};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 3'd2, 32'h4000_0040, 32'h0,        32'h1111_1111, 0, 1'b0, 0, 0, 1'b0, 32'hA5A5_0011};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 3'd2, 32'h4000_0044, 32'h0,        32'h2222_2222, 0, 1'b0, 0, 0, 1'b0, 32'hA5A5_0011};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 3'd2, 32'h4000_0014, 32'h0,        32'h0BAD_F00D, 0, 1'b0, 2, 1, 1'b0, 32'h0BAD_F00D};
        vecs[10] = '{1'b1, 2'b10, 1'b1, 3'd1, 32'h4000_0018, 32'h5A5A_5A5A, 32'h0,       0, 1'b0, 1, 0, 1'b1, 32'h0BAD_F00D};

        hreset = 1'b1;
        hwdata = '0;
        bus_idle();
        tick();
        tick();
        chk("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("rst_hresp",     {31'b0, hresp},     32'd0);
        chk("rst_hrdata",    hrdata,             32'd0);
        chk("rst_psel",      {31'b0, psel},      32'd0);
        chk("rst_penable",   {31'b0, penable},   32'd0);
        chk("rst_pwrite",    {31'b0, pwrite},    32'd0);
        chk("rst_paddr",     paddr,              32'd0);
        chk("rst_pwdata",    pwdata,             32'd0);
        hreset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-to-back read then write, second address phase taken in the completing cycle.
        ready_delay = 0;
        prdata_v    = 32'h1111_2222;
        addr_phase(2'b10, 1'b0, 3'd2, 32'h4000_0100);
        tick();
        chk("b2b_rd_setup_psel",    {31'b0, psel},      32'd1);
        chk("b2b_rd_setup_penable", {31'b0, penable},   32'd0);
        chk("b2b_rd_setup_hready",  {31'b0, hreadyout}, 32'd0);
        bus_idle();
        tick();
        chk("b2b_rd_access_penable", {31'b0, penable}, 32'd1);
        tick();
        chk("b2b_rd_done_hready", {31'b0, hreadyout}, 32'd1);
        chk("b2b_rd_done_hrdata", hrdata, 32'h1111_2222);
        addr_phase(2'b10, 1'b1, 3'd2, 32'h4000_0104);
        tick();
        chk("b2b_wr_setup_psel",    {31'b0, psel},    32'd1);
        chk("b2b_wr_setup_penable", {31'b0, penable}, 32'd0);
        chk("b2b_wr_setup_pwrite",  {31'b0, pwrite},  32'd1);
        chk("b2b_wr_setup_paddr",   paddr,            32'h4000_0104);
        bus_idle();
        hwdata = 32'h9ABC_DEF0;
        tick();
        chk("b2b_wr_access_penable", {31'b0, penable}, 32'd1);
        chk("b2b_wr_access_pwdata",  pwdata,           32'h9ABC_DEF0);
        tick();
        chk("b2b_wr_done_hready", {31'b0, hreadyout}, 32'd1);
        chk("b2b_wr_done_hresp",  {31'b0, hresp},     32'd0);
        hwdata = '0;

        // Slave error, then a new NONSEQ accepted during the second error cycle.
        slverr_v = 1'b1;
        prdata_v = 32'hEEEE_EEEE;
        addr_phase(2'b10, 1'b0, 3'd2, 32'h4000_0200);
        tick();
        bus_idle();
        tick();
        tick();
        chk("err1_hresp",  {31'b0, hresp},     32'd1);
        chk("err1_hready", {31'b0, hreadyout}, 32'd0);
        chk("err1_psel",   {31'b0, psel},      32'd0);
        tick();
        chk("err2_hresp",  {31'b0, hresp},     32'd1);
        chk("err2_hready", {31'b0, hreadyout}, 32'd1);
        slverr_v = 1'b0;
        prdata_v = 32'h5555_AAAA;
        addr_phase(2'b10, 1'b0, 3'd2, 32'h4000_0204);
        tick();
        chk("err2_next_psel",  {31'b0, psel},  32'd1);
        chk("err2_next_hresp", {31'b0, hresp}, 32'd0);
        chk("err2_next_paddr", paddr,          32'h4000_0204);
        bus_idle();
        tick();
        tick();
        chk("err2_next_hready", {31'b0, hreadyout}, 32'd1);
        chk("err2_next_hrdata", hrdata,             32'h5555_AAAA);

        // Reset while the slave is stalling in ACCESS.
        ready_delay = 255;
        prdata_v    = 32'h3333_3333;
        addr_phase(2'b10, 1'b0, 3'd2, 32'h4000_0300);
        tick();
        bus_idle();
        tick();
        chk("rstacc_penable_before", {31'b0, penable}, 32'd1);
        hreset = 1'b1;
        tick();
        chk("rstacc_psel",    {31'b0, psel},      32'd0);
        chk("rstacc_penable", {31'b0, penable},   32'd0);
        chk("rstacc_hready",  {31'b0, hreadyout}, 32'd1);
        chk("rstacc_hresp",   {31'b0, hresp},     32'd0);
        chk("rstacc_hrdata",  hrdata,             32'd0);
        chk("rstacc_paddr",   paddr,              32'd0);
        hreset = 1'b0;
        tick();
        chk("rstacc_after_hready", {31'b0, hreadyout}, 32'd1);
        chk("rstacc_after_psel",   {31'b0, psel},      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
